// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: oversampling Philips I2S receiver.
// Synchronises BCK/WS/DATA into i_clk and assembles MSB-aligned left/right words.
// A new frame is presented with a one-cycle o_valid strobe.
// Optional peak-magnitude tracking is built only when I2S_RX_PEAK_EN is defined.
module i2s_rx_deser #(
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bck,
  input  logic              i_ws,
  input  logic              i_data,
`ifdef I2S_RX_PEAK_EN
  input  logic              i_peak_clr,
  output logic [DATA_W-2:0] o_peak_l,
  output logic [DATA_W-2:0] o_peak_r,
`endif
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic              o_valid,
  output logic              o_locked,
  output logic [5:0]        o_bits
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_SYNC, S_LEFT, S_RIGHT} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        bck_sync_reg;
  logic [1:0]        ws_sync_reg, data_sync_reg;
  logic [DATA_W-1:0] word_reg, word_next;
  logic [5:0]        bitcnt_reg, bitcnt_next;
  logic              ws_prev_reg, ws_prev_next;
  logic [TW-1:0]     tmo_reg, tmo_next;
  logic [DATA_W-1:0] left_hold_reg, left_hold_next;
  logic              have_left_reg, have_left_next;
  logic [DATA_W-1:0] left_reg, left_next, right_reg, right_next;
  logic              valid_reg, valid_next, locked_reg, locked_next;
  logic [5:0]        bits_reg, bits_next;

  logic              rise, ws_bit, data_bit;
  logic [DATA_W-1:0] bit_sel, closed_word;
  logic [5:0]        bits_inc;

  // Two-flop synchronisers; the third BCK stage exists only for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bck_sync_reg  <= '0;
      ws_sync_reg   <= '0;
      data_sync_reg <= '0;
    end else begin
      bck_sync_reg  <= {bck_sync_reg[1:0], i_bck};
      ws_sync_reg   <= {ws_sync_reg[0], i_ws};
      data_sync_reg <= {data_sync_reg[0], i_data};
    end
  end

  assign rise     = bck_sync_reg[1] & ~bck_sync_reg[2];
  assign ws_bit   = ws_sync_reg[1];
  assign data_bit = data_sync_reg[1];
  assign bits_inc = (bitcnt_reg == 6'd63) ? 6'd63 : bitcnt_reg + 6'd1;

  // One-hot write position for the current bit; none set once the word is full,
  // which truncates long words while keeping their MSBs.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bitcnt_reg == 6'(DATA_W - 1 - gi));
    end
  endgenerate

  assign closed_word = (word_reg & ~bit_sel) | (bit_sel & {DATA_W{data_bit}});

  // State and datapath register update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= S_SYNC;
      word_reg      <= '0;
      bitcnt_reg    <= '0;
      ws_prev_reg   <= 1'b0;
      tmo_reg       <= '0;
      left_hold_reg <= '0;
      have_left_reg <= 1'b0;
      left_reg      <= '0;
      right_reg     <= '0;
      valid_reg     <= 1'b0;
      locked_reg    <= 1'b0;
      bits_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      word_reg      <= word_next;
      bitcnt_reg    <= bitcnt_next;
      ws_prev_reg   <= ws_prev_next;
      tmo_reg       <= tmo_next;
      left_hold_reg <= left_hold_next;
      have_left_reg <= have_left_next;
      left_reg      <= left_next;
      right_reg     <= right_next;
      valid_reg     <= valid_next;
      locked_reg    <= locked_next;
      bits_reg      <= bits_next;
    end
  end

  // Next-state: bit capture and word close on BCK rise, otherwise timeout.
  always_comb begin
    state_next     = state_reg;
    word_next      = word_reg;
    bitcnt_next    = bitcnt_reg;
    ws_prev_next   = ws_prev_reg;
    tmo_next       = (tmo_reg == TW'(TIMEOUT_CYC)) ? tmo_reg : tmo_reg + TW'(1);
    left_hold_next = left_hold_reg;
    have_left_next = have_left_reg;
    left_next      = left_reg;
    right_next     = right_reg;
    valid_next     = 1'b0;
    locked_next    = locked_reg;
    bits_next      = bits_reg;
    if (rise) begin
      tmo_next = '0;
      if (ws_bit != ws_prev_reg) begin
        // WS edge: this bit is the LSB of the word that is ending.
        word_next    = '0;
        bitcnt_next  = '0;
        ws_prev_next = ws_bit;
        case (state_reg)
          S_SYNC: begin
            have_left_next = 1'b0;
            state_next     = ws_bit ? S_RIGHT : S_LEFT;
          end
          S_LEFT: begin
            if (ws_bit) begin
              left_hold_next = closed_word;
              have_left_next = 1'b1;
              state_next     = S_RIGHT;
            end
          end
          S_RIGHT: begin
            if (!ws_bit) begin
              // A right word with no preceding left word is dropped.
              if (have_left_reg) begin
                left_next   = left_hold_reg;
                right_next  = closed_word;
                bits_next   = bits_inc;
                valid_next  = 1'b1;
                locked_next = 1'b1;
              end
              state_next = S_LEFT;
            end
          end
          default: state_next = S_SYNC;
        endcase
      end else begin
        word_next   = closed_word;
        bitcnt_next = bits_inc;
      end
    end else if (tmo_reg >= TW'(TIMEOUT_CYC - 1)) begin
      // Counter reaches the threshold this cycle: stream considered dead.
      locked_next    = 1'b0;
      state_next     = S_SYNC;
      word_next      = '0;
      bitcnt_next    = '0;
      have_left_next = 1'b0;
    end
  end

  assign o_left   = left_reg;
  assign o_right  = right_reg;
  assign o_valid  = valid_reg;
  assign o_locked = locked_reg;
  assign o_bits   = bits_reg;

`ifdef I2S_RX_PEAK_EN
  logic [DATA_W-2:0] peak_l_reg, peak_r_reg, mag_l, mag_r;

  // Two's complement magnitude; the most negative code saturates to all-ones.
  function automatic logic [DATA_W-2:0] magnitude(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] neg;
    neg = ~s + 1'b1;
    if (!s[DATA_W-1])     magnitude = s[DATA_W-2:0];
    else if (neg[DATA_W-1]) magnitude = '1;
    else                    magnitude = neg[DATA_W-2:0];
  endfunction

  assign mag_l = magnitude(left_reg);
  assign mag_r = magnitude(right_reg);

  // Peak hold; a clear coinciding with a new frame restarts from that frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak_l_reg <= '0;
      peak_r_reg <= '0;
    end else if (valid_reg) begin
      peak_l_reg <= (i_peak_clr || mag_l > peak_l_reg) ? mag_l : peak_l_reg;
      peak_r_reg <= (i_peak_clr || mag_r > peak_r_reg) ? mag_r : peak_r_reg;
    end else if (i_peak_clr) begin
      peak_l_reg <= '0;
      peak_r_reg <= '0;
    end
  end

  assign o_peak_l = peak_l_reg;
  assign o_peak_r = peak_r_reg;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: directed bench for i2s_rx_deser (DATA_W=24, TIMEOUT_CYC=255).
// Frames are driven as Philips I2S; expected samples are queued at each closing
// BCK rise and matched against o_valid strobes by a monitor.
module tb_i2s_rx_deser;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_bck = 1'b0;
  logic        i_ws = 1'b0;
  logic        i_data = 1'b0;
  logic [23:0] o_left, o_right;
  logic        o_valid, o_locked;
  logic [5:0]  o_bits;
`ifdef I2S_RX_PEAK_EN
  logic        i_peak_clr = 1'b0;
  logic [22:0] o_peak_l, o_peak_r;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [5:0]  b;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  i2s_rx_deser #(.DATA_W(24), .TIMEOUT_CYC(255)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bck(i_bck), .i_ws(i_ws), .i_data(i_data),
`ifdef I2S_RX_PEAK_EN
    .i_peak_clr(i_peak_clr), .o_peak_l(o_peak_l), .o_peak_r(o_peak_r),
`endif
    .o_left(o_left), .o_right(o_right), .o_valid(o_valid),
    .o_locked(o_locked), .o_bits(o_bits)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // One BCK period: falling half carries WS/DATA changes, then the rise.
  task automatic send_period(input logic w, input logic d, input int h);
    i_bck = 1'b0; i_ws = w; i_data = d;
    repeat (h) @(negedge i_clk);
    i_bck = 1'b1;
    repeat (h) @(negedge i_clk);
  endtask

  // Full frame of n-bit slots; the last period is the closing rise of the right word.
  task automatic send_frame(input int n, input logic [31:0] ls, input logic [31:0] rs,
                            input int h, input bit emit, input logic [23:0] el,
                            input logic [23:0] er, input logic [5:0] eb);
    exp_t e;
    for (int k = 0; k < n - 1; k++) send_period(1'b0, ls[n-1-k], h);
    send_period(1'b1, ls[0], h);
    for (int k = 0; k < n - 1; k++) send_period(1'b1, rs[n-1-k], h);
    i_bck = 1'b0; i_ws = 1'b0; i_data = rs[0];
    repeat (h) @(negedge i_clk);
    i_bck = 1'b1;
    if (emit) begin
      e.l = el; e.r = er; e.b = eb; e.c = cyc;
      exp_q.push_back(e);
    end
    repeat (h) @(negedge i_clk);
  endtask

  task automatic drain_check(input string tag);
    repeat (8) @(negedge i_clk);
    check_value(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Match each strobe against the oldest queued frame; also check its latency.
  always @(negedge i_clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_valid", 32'(o_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_value("left", 32'(o_left), 32'(mon_e.l));
        check_value("right", 32'(o_right), 32'(mon_e.r));
        check_value("bits", 32'(o_bits), 32'(mon_e.b));
        check_value("locked_on_valid", 32'(o_locked), 32'd1);
        check_value("valid_latency", 32'(cyc - mon_e.c), 32'd3);
      end
    end
  end

  initial begin
    int t0;
    int fall;

    // Reset state.
    repeat (3) @(negedge i_clk);
    check_value("rst_left", 32'(o_left), 32'd0);
    check_value("rst_right", 32'(o_right), 32'd0);
    check_value("rst_valid", 32'(o_valid), 32'd0);
    check_value("rst_locked", 32'(o_locked), 32'd0);
    check_value("rst_bits", 32'(o_bits), 32'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // 32-bit slots, BCK = clk/8: first frame suppressed, second emitted.
    send_frame(32, 32'h12345600, 32'hABCDEF00, 4, 1'b0, 24'h0, 24'h0, 6'd0);
    send_frame(32, 32'h12345600, 32'hABCDEF00, 4, 1'b1, 24'h123456, 24'hABCDEF, 6'd32);
    drain_check("missed_frame_32");
    check_value("locked_32", 32'(o_locked), 32'd1);

    // 16-bit words are zero-padded in the LSBs.
    send_frame(16, 32'h8001, 32'h7FFF, 4, 1'b1, 24'h800100, 24'h7FFF00, 6'd16);
    drain_check("missed_frame_16");

    // Stop BCK mid-left word: lock drops about 255 cycles after the last rise.
    for (int k = 0; k < 5; k++) send_period(1'b0, 1'b1, 4);
    i_bck = 1'b0;
    t0 = cyc;
    check_value("locked_before_stall", 32'(o_locked), 32'd1);
    fall = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (!o_locked && fall < 0) fall = cyc - t0;
    end
    check_value("timeout_in_window", 32'(fall >= 250 && fall <= 258), 32'd1);
    check_value("locked_after_stall", 32'(o_locked), 32'd0);
    check_value("left_held", 32'(o_left), 32'h800100);
    check_value("right_held", 32'(o_right), 32'h7FFF00);

    // Restart: one frame passes silently, then output resumes.
    send_frame(32, 32'h00FF0000, 32'hFFFFFF00, 4, 1'b0, 24'h0, 24'h0, 6'd0);
    send_frame(32, 32'h00FF0000, 32'hFFFFFF00, 4, 1'b1, 24'h00FF00, 24'hFFFFFF, 6'd32);
    drain_check("missed_frame_restart");

    // Reset in the middle of a right word.
    for (int k = 0; k < 23; k++) send_period(1'b0, 1'b1, 4);
    for (int k = 0; k < 6; k++) send_period(1'b1, 1'b0, 4);
    i_bck = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    check_value("midrst_left", 32'(o_left), 32'd0);
    check_value("midrst_right", 32'(o_right), 32'd0);
    check_value("midrst_locked", 32'(o_locked), 32'd0);
    check_value("midrst_bits", 32'(o_bits), 32'd0);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    send_frame(24, 32'h7FFFFF, 32'h800000, 4, 1'b0, 24'h0, 24'h0, 6'd0);
    send_frame(24, 32'h7FFFFF, 32'h800000, 4, 1'b1, 24'h7FFFFF, 24'h800000, 6'd24);
    drain_check("missed_frame_24");

    // Maximum rate, BCK = clk/4, 8-bit slots.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] l8, r8;
      l8 = 8'(i * 7 + 3);
      r8 = ~8'(i);
      send_frame(8, {24'h0, l8}, {24'h0, r8}, 2, 1'b1, {l8, 16'h0}, {r8, 16'h0}, 6'd8);
    end
    drain_check("missed_frame_maxrate");

`ifdef I2S_RX_PEAK_EN
    send_frame(24, 32'hC00000, 32'h0, 2, 1'b1, 24'hC00000, 24'h0, 6'd24);
    send_frame(24, 32'h100000, 32'h0, 2, 1'b1, 24'h100000, 24'h0, 6'd24);
    drain_check("missed_frame_peak");
    check_value("peak_l_max", 32'(o_peak_l), 32'h400000);
    send_frame(24, 32'h000010, 32'h0, 2, 1'b1, 24'h000010, 24'h0, 6'd24);
    for (int i = 0; i < 10; i++) begin
      if (o_valid) break;
      @(negedge i_clk);
    end
    i_peak_clr = 1'b1;
    @(negedge i_clk);
    i_peak_clr = 1'b0;
    @(negedge i_clk);
    check_value("peak_l_clr_with_valid", 32'(o_peak_l), 32'h000010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
